// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Generic pipeline stage register with a valid/ready handshake,
//               a 2-entry skid buffer (main + skid) for full throughput under
//               backpressure, a synchronous flush that forces a bubble, and a
//               saturating backpressure cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int DATA_W     = 32,
  parameter int DST_W      = 4,
  parameter int CTRL_W     = 6,
  parameter int FLUSH_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DST_W-1:0]  out_dst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cycles
);

  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_main_data;
  logic [DST_W-1:0]    r_main_dst;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [DST_W-1:0]    r_skid_dst;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [15:0]         r_stall_cycles;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_main_valid;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  // Handshake decode; in_ready depends only on registered state and rst,
  // so there is no combinational path from out_ready back to in_ready.
  assign w_main_valid = (r_state != ST_EMPTY);
  assign in_ready     = (r_state != ST_FULL) && !rst;
  assign w_in_xfer    = in_valid && in_ready;
  assign w_out_xfer   = w_main_valid && out_ready;

  // Occupancy FSM next state and datapath load selects.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (w_out_xfer) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register: reset and flush both return to EMPTY, discarding entries.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main/skid entry storage; flush kills ctrl and skid, optionally payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_dst  <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_dst  <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_dst  <= '0;
      r_skid_ctrl <= '0;
      if (FLUSH_ZERO != 0) begin
        r_main_data <= '0;
        r_main_dst  <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_dst  <= in_dst;
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_dst  <= r_skid_dst;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_dst  <= in_dst;
        r_skid_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_skid_data <= '0;
        r_skid_dst  <= '0;
        r_skid_ctrl <= '0;
      end
    end
  end

  // Saturating count of backpressured cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cycles != c_STALL_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  // Outputs; ctrl is forced to zero on a bubble so write-enables never leak.
  assign out_valid    = w_main_valid;
  assign out_data     = r_main_data;
  assign out_dst      = r_main_dst;
  assign out_ctrl     = w_main_valid ? r_main_ctrl : '0;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Scoreboard bench for pipe_skid_stage. The driver pushes each
//               accepted word into an expected queue; the monitor pops and
//               compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_dst;
  logic [5:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dst;
  logic [5:0]  out_ctrl;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_q[$];

  pipe_skid_stage #(
    .DATA_W    (32),
    .DST_W     (4),
    .CTRL_W    (6),
    .FLUSH_ZERO(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dst      (in_dst),
    .in_ctrl     (in_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dst     (out_dst),
    .out_ctrl    (out_ctrl),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: output transfers happen at the next posedge; sample at negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 32'hDEAD_BEEF);
        end else begin
          logic [41:0] e;
          e = exp_q.pop_front();
          chk("sb_data", out_data, e[41:10]);
          chk("sb_dst",  {28'd0, out_dst},  {28'd0, e[9:6]});
          chk("sb_ctrl", {26'd0, out_ctrl}, {26'd0, e[5:0]});
        end
      end
      if (out_valid !== 1'b1) begin
        chk("bubble_ctrl", {26'd0, out_ctrl}, 32'd0);
      end
    end
  end

  // Present one word and hold until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [3:0] dst, input logic [5:0] c);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_dst   = dst;
    in_ctrl  = c;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({d, dst, c});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dst    = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;

    // 1: reset for two cycles, then release
    tick(2);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_data", out_data, 32'd0);
    chk("rel_out_dst", {28'd0, out_dst}, 32'd0);
    chk("rel_out_ctrl", {26'd0, out_ctrl}, 32'd0);
    chk("rel_stall", {16'd0, stall_cycles}, 32'd0);

    // 2: streaming with out_ready=1, one cycle latency, no gaps
    out_ready = 1'b1;
    send(32'h11, 4'h1, 6'h01);
    chk("s2_v1", {31'd0, out_valid}, 32'd1);
    chk("s2_d1", out_data, 32'h11);
    send(32'h22, 4'h2, 6'h02);
    chk("s2_d2", out_data, 32'h22);
    send(32'h33, 4'h3, 6'h03);
    chk("s2_d3", out_data, 32'h33);
    tick(1);
    chk("s2_drained", {31'd0, out_valid}, 32'd0);
    chk("s2_hold_data", out_data, 32'h33);
    chk("s2_stall", {16'd0, stall_cycles}, 32'd0);

    // 3: backpressure fills skid, then drains in order
    out_ready = 1'b0;
    send(32'hA, 4'hA, 6'h0A);
    send(32'hB, 4'hB, 6'h0B);
    chk("s3_full_ready", {31'd0, in_ready}, 32'd0);
    chk("s3_head", out_data, 32'hA);
    tick(3);
    chk("s3_stall", {16'd0, stall_cycles}, 32'd4);
    out_ready = 1'b1;
    tick(1);
    chk("s3_ready_again", {31'd0, in_ready}, 32'd1);
    chk("s3_second", out_data, 32'hB);
    tick(1);
    chk("s3_empty", {31'd0, out_valid}, 32'd0);
    chk("s3_stall_hold", {16'd0, stall_cycles}, 32'd4);

    // 4: flush while FULL with in_valid; nothing survives
    out_ready = 1'b0;
    send(32'hA, 4'h5, 6'h15);
    send(32'hB, 4'h6, 6'h16);
    in_valid = 1'b1;
    in_data  = 32'hC;
    in_dst   = 4'h7;
    in_ctrl  = 6'h17;
    flush    = 1'b1;
    exp_q.delete();
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("s4_valid", {31'd0, out_valid}, 32'd0);
    chk("s4_ctrl", {26'd0, out_ctrl}, 32'd0);
    chk("s4_data_zero", out_data, 32'd0);
    chk("s4_dst_zero", {28'd0, out_dst}, 32'd0);
    chk("s4_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(4);
    chk("s4_no_c", {31'd0, out_valid}, 32'd0);

    // 4b: flush while ONE drops a same-cycle accepted input
    out_ready = 1'b0;
    send(32'hD, 4'h8, 6'h18);
    in_valid = 1'b1;
    in_data  = 32'hE;
    in_dst   = 4'h9;
    in_ctrl  = 6'h19;
    flush    = 1'b1;
    exp_q.delete();
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("s4b_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick(4);
    chk("s4b_no_e", {31'd0, out_valid}, 32'd0);

    // 5: long stall saturates the counter
    out_ready = 1'b0;
    send(32'h55, 4'h5, 6'h25);
    tick(70000);
    chk("s5_saturate", {16'd0, stall_cycles}, 32'h0000_FFFF);
    chk("s5_head", out_data, 32'h55);

    // 6: reset while FULL with in_valid; no stale word afterwards
    send(32'h66, 4'h6, 6'h26);
    chk("s6_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h77;
    in_dst   = 4'h7;
    in_ctrl  = 6'h27;
    rst      = 1'b1;
    #1;
    chk("s6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    tick(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("s6_valid", {31'd0, out_valid}, 32'd0);
    chk("s6_data", out_data, 32'd0);
    chk("s6_stall", {16'd0, stall_cycles}, 32'd0);
    chk("s6_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(4);
    chk("s6_no_stale", {31'd0, out_valid}, 32'd0);
    send(32'h88, 4'hC, 6'h2C);
    chk("s6_after", out_data, 32'h88);
    chk("s6_after_ctrl", {26'd0, out_ctrl}, 32'h2C);
    tick(3);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
